// File: rtl/ceyloniac_alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for the two-requester ALU scheduler.
// Multiply support is gated by CEYLONIAC_ALU_SCHED_MUL_EN in the files that import this package.
package ceyloniac_alu_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefOpWidth   = 4;
    localparam int unsigned DefMulCycles = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_PASS = 4'b1011;
    localparam logic [3:0] OP_RSVD = 4'b1110;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWaitMul,
        StResp
    } state_e;

endpackage

// File: rtl/ceyloniac_alu.sv
// Combinational ALU; results truncated to the data width. Multiply only when
// CEYLONIAC_ALU_SCHED_MUL_EN is defined, otherwise opcode OP_MUL reports an error.
module ceyloniac_alu
    import ceyloniac_alu_pkg::*;
#(
    parameter int unsigned ALU_DATA_WIDTH = DefDataWidth,
    parameter int unsigned ALU_OP_WIDTH   = DefOpWidth
) (
    input  logic [ALU_DATA_WIDTH-1:0] a_i,
    input  logic [ALU_DATA_WIDTH-1:0] b_i,
    input  logic [ALU_OP_WIDTH-1:0]   op_i,
    output logic [ALU_DATA_WIDTH-1:0] result_o,
    output logic                      err_o,
    output logic [3:0]                alu_status_o
);

    localparam int unsigned ShW = $clog2(ALU_DATA_WIDTH);

    logic [ShW-1:0]          shamt;
    logic [ALU_DATA_WIDTH:0] sum_ext;

    assign shamt   = b_i[ShW-1:0];
    assign sum_ext = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        result_o = '0;
        err_o    = 1'b0;
        case (op_i)
            ALU_OP_WIDTH'(OP_ADD):  result_o = sum_ext[ALU_DATA_WIDTH-1:0];
            ALU_OP_WIDTH'(OP_SUB):  result_o = a_i - b_i;
            ALU_OP_WIDTH'(OP_AND):  result_o = a_i & b_i;
            ALU_OP_WIDTH'(OP_OR):   result_o = a_i | b_i;
            ALU_OP_WIDTH'(OP_XOR):  result_o = a_i ^ b_i;
            ALU_OP_WIDTH'(OP_SLL):  result_o = a_i << shamt;
            ALU_OP_WIDTH'(OP_SRL):  result_o = a_i >> shamt;
            ALU_OP_WIDTH'(OP_SRA):  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OP_WIDTH'(OP_SLT):  result_o = ALU_DATA_WIDTH'($signed(a_i) < $signed(b_i));
            ALU_OP_WIDTH'(OP_SLTU): result_o = ALU_DATA_WIDTH'(a_i < b_i);
            ALU_OP_WIDTH'(OP_PASS): result_o = a_i;
`ifdef CEYLONIAC_ALU_SCHED_MUL_EN
            ALU_OP_WIDTH'(OP_MUL):  result_o = a_i * b_i;
`else
            ALU_OP_WIDTH'(OP_MUL):  err_o = 1'b1;
`endif
            ALU_OP_WIDTH'(OP_RSVD): err_o = 1'b1;
            default:                err_o = 1'b1;
        endcase
    end

    // {zero, negative, add carry-out, error}
    assign alu_status_o = {result_o == '0, result_o[ALU_DATA_WIDTH-1], sum_ext[ALU_DATA_WIDTH],
                           err_o};

endmodule

// File: rtl/ceyloniac_alu_sched.sv
// Two-requester round-robin front end around a single shared ALU, one operation in flight.
// Define CEYLONIAC_ALU_SCHED_MUL_EN to enable the multi-cycle multiply path (WAIT_MUL state).
module ceyloniac_alu_sched
    import ceyloniac_alu_pkg::*;
#(
    parameter int unsigned ALU_DATA_WIDTH = DefDataWidth,
    parameter int unsigned ALU_OP_WIDTH   = DefOpWidth,
    parameter int unsigned MUL_CYCLES     = DefMulCycles
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [2*ALU_DATA_WIDTH-1:0] req_a,
    input  logic [2*ALU_DATA_WIDTH-1:0] req_b,
    input  logic [2*ALU_OP_WIDTH-1:0]   req_op,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [ALU_DATA_WIDTH-1:0]   rsp_data,
    output logic                        rsp_err,
    output logic                        busy
);

    state_e                    state_q, state_d;
    logic [ALU_DATA_WIDTH-1:0] a_q, b_q, rsp_data_q;
    logic [ALU_OP_WIDTH-1:0]   op_q;
    logic                      id_q, last_grant_q, rsp_err_q;
    logic                      grant_id, accept, rsp_hs, load_result;
    logic [ALU_DATA_WIDTH-1:0] alu_result;
    logic                      alu_err;
    logic [3:0]                alu_status_unused;

    // Both valid: favour whoever was not served last.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    assign accept = (state_q == StIdle) && (|req_valid);
    assign rsp_hs = (state_q == StResp) && rsp_ready[id_q];

`ifdef CEYLONIAC_ALU_SCHED_MUL_EN
    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [CntW-1:0] cnt_q;
    logic            is_mul;

    assign is_mul      = (op_q == ALU_OP_WIDTH'(OP_MUL));
    assign load_result = ((state_q == StExec) && !is_mul) ||
                         ((state_q == StWaitMul) && (cnt_q == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == StExec) && is_mul) begin
            cnt_q <= CntW'(MUL_CYCLES - 1);
        end else if ((state_q == StWaitMul) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    localparam int unsigned MulCyclesUnused = MUL_CYCLES;

    assign load_result = (state_q == StExec);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (|req_valid) state_d = StExec;
            end
`ifdef CEYLONIAC_ALU_SCHED_MUL_EN
            StExec:    state_d = is_mul ? StWaitMul : StResp;
            StWaitMul: begin
                if (cnt_q == '0) state_d = StResp;
            end
`else
            StExec:    state_d = StResp;
`endif
            StResp: begin
                if (rsp_ready[id_q]) state_d = StIdle;
            end
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        // rst also masks the combinational grant so nothing is accepted during reset.
        if (accept && !rst) req_ready[grant_id] = 1'b1;
        if (state_q == StResp) rsp_valid[id_q] = 1'b1;
        busy     = (state_q != StIdle);
        rsp_data = rsp_data_q;
        rsp_err  = rsp_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= grant_id ? req_a[2*ALU_DATA_WIDTH-1:ALU_DATA_WIDTH] :
                                   req_a[ALU_DATA_WIDTH-1:0];
                b_q  <= grant_id ? req_b[2*ALU_DATA_WIDTH-1:ALU_DATA_WIDTH] :
                                   req_b[ALU_DATA_WIDTH-1:0];
                op_q <= grant_id ? req_op[2*ALU_OP_WIDTH-1:ALU_OP_WIDTH] :
                                   req_op[ALU_OP_WIDTH-1:0];
                id_q <= grant_id;
            end
            if (load_result) begin
                rsp_data_q <= alu_result;
                rsp_err_q  <= alu_err;
            end
            if (rsp_hs) last_grant_q <= id_q;
        end
    end

    ceyloniac_alu #(
        .ALU_DATA_WIDTH (ALU_DATA_WIDTH),
        .ALU_OP_WIDTH   (ALU_OP_WIDTH)
    ) u_alu (
        .a_i          (a_q),
        .b_i          (b_q),
        .op_i         (op_q),
        .result_o     (alu_result),
        .err_o        (alu_err),
        .alu_status_o (alu_status_unused)
    );

endmodule

// File: tb/tb_ceyloniac_alu_sched.sv
// Directed bench for ceyloniac_alu_sched: reset, arbitration, latency, backpressure, error ops.
// Multiply-path checks are selected by CEYLONIAC_ALU_SCHED_MUL_EN.
module tb_ceyloniac_alu_sched;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [2*OW-1:0] req_op;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    int checks;
    int failures;

    ceyloniac_alu_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_op[id*OW +: OW] = op;
    endtask

    // Single non-multiply transaction from IDLE; response expected two cycles after handshake.
    task automatic run_op(input string tag, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_d, input logic exp_e);
        logic [1:0] sel;
        sel = 2'b01 << id;
        set_req(id, a, b, op);
        rsp_ready = 2'b00;
        req_valid = sel;
        #1;
        check({tag, ".req_ready"}, req_ready, sel);
        step();
        req_valid = 2'b00;
        check({tag, ".busy_T1"}, busy, 1);
        check({tag, ".rsp_valid_T1"}, rsp_valid, 0);
        step();
        check({tag, ".rsp_valid_T2"}, rsp_valid, sel);
        check({tag, ".rsp_data"}, rsp_data, exp_d);
        check({tag, ".rsp_err"}, rsp_err, exp_e);
        rsp_ready = sel;
        step();
        rsp_ready = 2'b00;
        check({tag, ".idle_after"}, busy, 0);
    endtask

`ifdef CEYLONIAC_ALU_SCHED_MUL_EN
    // Multiply on requester 0 with MUL_CYCLES=4: response at T+6.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d);
        set_req(0, a, b, 4'b0010);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        #1;
        check({tag, ".req_ready"}, req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            check({tag, ".busy_wait"}, busy, 1);
            check({tag, ".rsp_valid_wait"}, rsp_valid, 0);
            step();
        end
        check({tag, ".rsp_valid_T6"}, rsp_valid, 2'b01);
        check({tag, ".rsp_data"}, rsp_data, exp_d);
        check({tag, ".rsp_err"}, rsp_err, 0);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        check({tag, ".idle_after"}, busy, 0);
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        #1;
        check("reset.req_ready", req_ready, 0);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_data", rsp_data, 0);
        check("reset.rsp_err", rsp_err, 0);
        check("reset.busy", busy, 0);

        // Contention out of reset: 0,1,0,1 with both continuously valid.
        set_req(0, 32'd1, 32'd2, 4'b0000);
        set_req(1, 32'd10, 32'd4, 4'b0001);
        rsp_ready = 2'b11;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            check("rr.req_ready", req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
            step();
            check("rr.req_ready_exec", req_ready, 0);
            step();
            check("rr.rsp_valid", rsp_valid, (n % 2 == 0) ? 2'b01 : 2'b10);
            check("rr.rsp_data", rsp_data, (n % 2 == 0) ? 32'd3 : 32'd6);
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        run_op("add", 0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0);

        // Backpressure on requester 1; requester 0's rsp_ready must be ignored.
        set_req(0, 32'd5, 32'd7, 4'b0000);
        set_req(1, 32'h0000_F0F0, 32'h0000_FF00, 4'b0011);
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        #1;
        check("bp.req_ready", req_ready, 2'b10);
        step();
        check("bp.busy", busy, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp.rsp_valid", rsp_valid, 2'b10);
            check("bp.rsp_data", rsp_data, 32'h0000_F000);
            check("bp.rsp_err", rsp_err, 0);
            check("bp.req_ready_held", req_ready, 0);
            step();
        end
        rsp_ready = 2'b10;
        check("bp.rsp_valid_last", rsp_valid, 2'b10);
        step();
        check("bp.next_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;

        run_op("rsvd", 0, 32'd123, 32'd4, 4'b1110, 32'd0, 1'b1);
        run_op("sub", 1, 32'd3, 32'd5, 4'b0001, 32'hFFFF_FFFE, 1'b0);
        run_op("sll", 0, 32'd1, 32'd31, 4'b0110, 32'h8000_0000, 1'b0);
        run_op("sra", 1, 32'h8000_0000, 32'd4, 4'b1000, 32'hF800_0000, 1'b0);
        run_op("xor", 0, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'b0101, 32'hF00F_F00F, 1'b0);

`ifdef CEYLONIAC_ALU_SCHED_MUL_EN
        run_mul("mul", 32'd3, 32'd9, 32'd27);
        run_mul("mul_trunc", 32'h0001_0000, 32'h0001_0000, 32'd0);
        set_req(0, 32'd6, 32'd7, 4'b0010);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        step();
`else
        run_op("mul_off", 0, 32'd3, 32'd9, 4'b0010, 32'd0, 1'b1);
        set_req(0, 32'd1, 32'd1, 4'b0000);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
`endif
        // Reset with an operation in flight.
        check("rst_mid.busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid.busy", busy, 0);
        check("rst_mid.rsp_valid", rsp_valid, 0);
        step();
        rst = 1'b0;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            check("rst_mid.no_rsp", rsp_valid, 0);
            step();
        end
        rsp_ready = 2'b00;
        run_op("post_rst", 0, 32'd2, 32'd2, 4'b0000, 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ceyloniac_alu_sched.md
CEYLONIAC_ALU_SCHED -- requirements
Module: ceyloniac_alu_sched

Interface
REQ-001 SHALL have parameter ALU_DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ALU_OP_WIDTH, default 4, opcode width.
REQ-003 SHALL have parameter MUL_CYCLES, default 4, multiply occupancy in WAIT_MUL cycles (>=1).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-007 SHALL have port req_ready, output, 2, per-requester request accept.
REQ-008 SHALL have port req_a, input, 2*ALU_DATA_WIDTH, operand A, requester i in slice i.
REQ-009 SHALL have port req_b, input, 2*ALU_DATA_WIDTH, operand B, requester i in slice i.
REQ-010 SHALL have port req_op, input, 2*ALU_OP_WIDTH, opcode, requester i in slice i.
REQ-011 SHALL have port rsp_valid, output, 2, per-requester response valid.
REQ-012 SHALL have port rsp_ready, input, 2, per-requester response accept.
REQ-013 SHALL have port rsp_data, output, ALU_DATA_WIDTH, result shared by both requesters, qualified by rsp_valid.
REQ-014 SHALL have port rsp_err, output, 1, unsupported-op flag, qualified by rsp_valid.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, WAIT_MUL, RESP.
REQ-017 IDLE: if any req_valid, SHALL assert req_ready for exactly the granted requester (combinational), latch its a/b/op and id, go to EXEC; otherwise stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: single valid -> that requester; both valid -> requester not equal to last_grant.
REQ-019 last_grant SHALL update to the served id on the rsp handshake.
REQ-020 EXEC: if op is multiply (4'b0010) and multiply is enabled, SHALL load cnt=MUL_CYCLES-1 and go to WAIT_MUL.
REQ-021 EXEC, all other cases: SHALL register ALU output into rsp_data and go to RESP.
REQ-022 WAIT_MUL: SHALL decrement cnt; when cnt==0, SHALL register ALU output and go to RESP.
REQ-023 RESP: SHALL hold rsp_valid[id]=1 with stable rsp_data/rsp_err until rsp_ready[id]=1, then go to IDLE.
REQ-024 rsp_ready of the non-served requester SHALL be ignored.
REQ-025 Latency, request handshake at cycle T: non-multiply rsp_valid SHALL rise at T+2; multiply at T+2+MUL_CYCLES.
REQ-026 Opcode 4'b1110 SHALL return rsp_data=0, rsp_err=1.
REQ-027 All other supported ops SHALL return rsp_err=0.
REQ-028 Result width SHALL be ALU_DATA_WIDTH, truncated with no overflow flag, including multiply and shifts.
REQ-029 No new request SHALL be accepted while busy; no back-to-back acceptance without passing through IDLE.

Reset
REQ-030 rst SHALL asynchronously force: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, cnt=0, last_grant=1 (requester 0 wins first).
REQ-031 Reset mid-operation SHALL discard the in-flight operation and issue no response for it.

Configuration
REQ-032 Macro CEYLONIAC_ALU_SCHED_MUL_EN defined: multiply SHALL execute via WAIT_MUL per REQ-020/REQ-022.
REQ-033 Macro CEYLONIAC_ALU_SCHED_MUL_EN undefined: opcode 4'b0010 SHALL follow the non-multiply path (latency T+2) and return rsp_data=0, rsp_err=1.
REQ-034 With the macro undefined, WAIT_MUL and cnt logic SHALL be absent.

Structure
REQ-035 Package ceyloniac_alu_pkg SHALL hold: opcode constants (OP_ADD..OP_PASS, OP_MUL=4'b0010, OP_RSVD=4'b1110), FSM state encoding, and default width constants.
REQ-036 SHALL instantiate exactly one sub-module, ceyloniac_alu, fed only from the latched operand/opcode registers; its alu_status output SHALL be unused.

Verification
REQ-037 Directed test, single add: req0 a=5, b=7, op=0000 at T -> rsp_valid[0] at T+2, rsp_data=12, rsp_err=0.
REQ-038 Directed test, contention: both valid out of reset -> req0 served first, then req1; with both continuously valid, service alternates 0,1,0,1.
REQ-039 Directed test, multiply with MUL_EN, MUL_CYCLES=4: a=3, b=9 -> rsp_data=27 at T+6; busy high T+1..response handshake.
REQ-040 Directed test, backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_data held stable; req_ready stays 0 throughout.
REQ-041 Directed test, reserved op: op=1110 -> rsp_data=0, rsp_err=1; without MUL_EN, op=0010 -> rsp_data=0, rsp_err=1 at T+2.
REQ-042 Directed test, reset in WAIT_MUL: assert rst -> busy=0 and rsp_valid=0 immediately; the next request after reset is served normally.
